// File: rtl/byang_pkg.sv
// Shared definitions for the byang modular-inverse block family: operand width,
// the secp256k1 field prime and the arbiter's state encoding.
`ifndef BYANG_WIDTH
`define BYANG_WIDTH 256
`endif

package byang_pkg;

    localparam int BYANG_W = `BYANG_WIDTH;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/byang_inv_arb_rr_pick.sv
// Combinational rotating-priority picker: first asserted request at or above ptr,
// wrapping around, returned both one-hot and as an index.
module byang_inv_arb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int unsigned idx;

    // Walk from the farthest candidate back to ptr so the nearest hit is written last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                grant_idx = IDX_W'(idx);
                any       = 1'b1;
            end
        end
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/byang_inv_arb.sv
// Round-robin front end that time-shares one byang_inv core among N_REQ requesters,
// screening out operands that have no inverse before they reach the core.
module byang_inv_arb
    import byang_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = BYANG_W,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   inv_valid_in,
    input  logic                   inv_ready_in,
    output logic [WIDTH-1:0]       inv_a_in,
    input  logic                   inv_valid_out,
    output logic                   inv_ready_out,
    input  logic [WIDTH-1:0]       inv_result,
    output logic                   busy,
    output logic [IDX_W-1:0]       owner,
    output arb_state_e             dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
    localparam logic [WIDTH-1:0] P_W = WIDTH'(SECP256K1_P);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_q, rr_d;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] sel_op;
    logic             sel_bad;

    byang_inv_arb_rr_pick #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_pick (
        .req      (req_valid),
        .ptr      (rr_q),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (grant_any)
    );

    assign sel_op  = req_data[grant_idx*WIDTH +: WIDTH];
    // Zero and anything >= P have no inverse in the field; answer them without the core.
    assign sel_bad = (sel_op == '0) || (sel_op >= P_W);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        result_d      = result_q;
        err_d         = err_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        req_ready     = '0;
        rsp_valid     = '0;
        inv_valid_in  = 1'b0;
        inv_ready_out = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    op_d      = sel_op;
                    owner_d   = grant_idx;
                    rr_d      = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                    if (sel_bad) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = ARB_RESP;
                    end else begin
                        err_d    = 1'b0;
                        state_d  = ARB_ISSUE;
                    end
                end
            end
            ARB_ISSUE: begin
                inv_valid_in = 1'b1;
                if (inv_ready_in) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                inv_ready_out = 1'b1;
                if (inv_valid_out) begin
                    result_d = inv_result;
                    state_d  = ARB_RESP;
                end
            end
            ARB_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            owner_q  <= '0;
            rr_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
        end
    end

    assign rsp_data  = result_q;
    assign rsp_err   = err_q;
    assign inv_a_in  = op_q;
    assign busy      = (state_q != ARB_IDLE);
    assign owner     = owner_q;
    assign dbg_state = state_q;

endmodule

// File: doc/byang_inv_arb.md
Name: byang_inv_arb

Overview:
- Round-robin arbiter and sequencer that shares one byang_inv modular-inverse core (secp256k1 field) among N_REQ independent requesters.
- Accepts one operand at a time, screens out invalid operands, drives the core's valid/ready handshakes, and returns each result to the requester that issued it.
- Sits between client blocks (e.g. ECDSA/point-normalisation engines) and the single inverter instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 256, operand/result width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_data  in  N_REQ*WIDTH  operands; requester i in slice [i*WIDTH +: WIDTH].
- rsp_valid  out  N_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_data  out  WIDTH  shared response bus, meaningful while any rsp_valid is high.
- rsp_err  out  1  response flag: operand was 0 or >= P; rsp_data = 0.
- inv_valid_in  out  1  to core valid_in.
- inv_ready_in  in  1  from core ready_in (core accepting).
- inv_a_in  out  WIDTH  to core a_in.
- inv_valid_out  in  1  from core valid_out.
- inv_ready_out  out  1  to core ready_out.
- inv_result  in  WIDTH  from core result.
- busy  out  1  high in any state other than IDLE.
- owner  out  $clog2(N_REQ)  index of the current transaction's requester.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, inv_valid_in=0, inv_ready_out=0, inv_a_in=0, busy=0, owner=0, rr_ptr=0, state=IDLE.
- State machine: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Grant is combinational: the first asserted req_valid, searching from rr_ptr upward with wrap.
- req_ready[grant]=1 only in IDLE; the handshake completes in that same cycle.
- On handshake: capture operand into op_reg, owner <= grant, rr_ptr <= (grant+1) mod N_REQ.
- If operand == 0 or operand >= P: result_reg <= 0, err_reg <= 1, go to RESP (core never started).
- Otherwise: err_reg <= 0, go to ISSUE.

ISSUE:
- inv_valid_in=1 and inv_a_in=op_reg. inv_valid_in first goes high the cycle after the accept.
- Held stable until inv_ready_in=1; on that cycle go to WAIT.

WAIT:
- inv_ready_out=1.
- On inv_valid_out=1: result_reg <= inv_result, go to RESP.

RESP:
- rsp_valid[owner]=1, rsp_data=result_reg, rsp_err=err_reg, all held stable.
- On rsp_ready[owner]=1: go to IDLE. req_ready stays 0 during that cycle.

Rules and boundary conditions:
- No new request is accepted outside IDLE; the block runs one transaction at a time.
- Simultaneous requests: rotating priority, so each requester is served within N_REQ transactions while it holds req_valid.
- rsp_ready of non-owners is ignored.
- req_valid may drop before grant with no effect. A dropped request has no state to clean up.
- inv_valid_out outside WAIT is ignored; it is a protocol error and is flagged by a bench assertion.
- Asynchronous reset at any point returns everything to reset values. The core shares rst_n, so no in-flight operation survives.
- The P comparison is a full WIDTH-bit unsigned compare against the package constant.
- Total latency from accept to rsp_valid equals core latency + 2 cycles.
- Error path: rsp_valid is asserted 1 cycle after accept.

Decomposition:
- Shared package byang_pkg gets:
  - SECP256K1_P = FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFE FFFFFC2F
  - state encodings ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP
  - a WIDTH macro shared with byang_inv
- One sub-module, rr_pick: combinational rotating-priority picker. Inputs: req vector and rr_ptr. Outputs: one-hot grant, grant index, any.

Test Plan:
- Single request, requester 0, a=1 -> rsp_valid[0], rsp_data=1, rsp_err=0. inv_valid_in rises exactly 1 cycle after req handshake.
- Requester 2, a=2 -> rsp_data = 7FFFFFFF followed by six FFFFFFFF words then 7FFFFE18 (= (P+1)/2), rsp_err=0. Check result*2 mod P = 1.
- Requester 1, a=0, and a separate request a=P -> each gets rsp_err=1, rsp_data=0, rsp_valid 1 cycle after accept. inv_valid_in never asserts.
- All 4 requesters hold req_valid with distinct operands from reset -> grant order 0,1,2,3; then 1 re-requests alone and gets the next grant. Each response routes only to its owner.
- Owner delays rsp_ready 10 cycles while others request -> rsp_data/rsp_err stable, all req_ready=0 throughout; next grant comes 1 cycle after release. Core holds off inv_ready_in 5 cycles -> inv_a_in stable.
- Assert rst_n low during WAIT -> all outputs at reset values asynchronously. After release, a fresh a=1 request completes normally from rr_ptr=0.
